// File: rtl/goomba_spawner_if.sv
// Spawn/despawn handshake between the goomba spawner and the enemy block.
interface goomba_spawner_if;
    logic       start;
    logic       kill;
    logic [9:0] spawnX;
    logic [9:0] spawnY;
    logic       isAlive_in;
    logic       kill_Mario;

    modport master (
        output start, kill, spawnX, spawnY,
        input  isAlive_in, kill_Mario
    );

    modport slave (
        input  start, kill, spawnX, spawnY,
        output isAlive_in, kill_Mario
    );
endinterface

// File: rtl/goomba_spawner.sv
// Goomba spawner: walks a fixed 8-entry spawn table as the screen scrolls,
// issues one enemy at a time and tracks level status (done, hit, spawn error).
module goomba_spawner #(
    parameter logic [9:0] SPAWN_X  = 10'd480,
    parameter logic [2:0] ARM_WAIT = 3'd4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_clk,
    input  logic              Shift,
    input  logic              restart,
    goomba_spawner_if.master  bus,
    output logic [5:0]        scroll_count,
    output logic [2:0]        entry_idx,
    output logic              spawns_done,
    output logic              mario_hit,
    output logic              spawn_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        ARM    = 3'd2,
        ACTIVE = 3'd3,
        DONE   = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_rst_sync;
    logic       w_rst_n;
    logic       r_frame_prev;
    logic       w_frame_rise;
    logic [2:0] r_arm_cnt;
    logic       w_accept;
    logic       w_timeout;
    logic       w_kill_req;
    logic       r_start;
    logic       r_kill;
    logic [9:0] r_spawn_x;
    logic [9:0] r_spawn_y;
    logic [5:0] r_scroll;
    logic [2:0] r_entry;
    logic       r_done;
    logic       r_hit;
    logic       r_err;

    // Spawn table: scroll column at which each entry becomes due.
    function automatic logic [5:0] col_of(input logic [2:0] idx);
        case (idx)
            3'd0:    col_of = 6'd2;
            3'd1:    col_of = 6'd5;
            3'd2:    col_of = 6'd9;
            3'd3:    col_of = 6'd12;
            3'd4:    col_of = 6'd16;
            3'd5:    col_of = 6'd20;
            3'd6:    col_of = 6'd25;
            default: col_of = 6'd30;
        endcase
    endfunction

    // Spawn table: ground height for each entry.
    function automatic logic [9:0] y_of(input logic [2:0] idx);
        case (idx)
            3'd2, 3'd5: y_of = 10'd320;
            default:    y_of = 10'd400;
        endcase
    endfunction

    assign w_rst_n      = r_rst_sync[1];
    assign w_frame_rise = frame_clk & ~r_frame_prev;

    // Reset asserts immediately but releases two Clk edges after Reset_n rises.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    // State register.
    always_ff @(posedge Clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic; restart beats kill_Mario, which beats normal flow.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_timeout  = 1'b0;
        w_kill_req = restart | (bus.kill_Mario & (r_state != HALT));
        if (restart) begin
            w_next = IDLE;
        end else if (bus.kill_Mario && r_state != HALT) begin
            w_next = HALT;
        end else begin
            case (r_state)
                IDLE:   if (!bus.isAlive_in && r_scroll >= col_of(r_entry)) w_next = ISSUE;
                ISSUE:  w_next = ARM;
                ARM: begin
                    if (bus.isAlive_in) begin
                        w_next   = ACTIVE;
                        w_accept = 1'b1;
                    end else if (r_arm_cnt == ARM_WAIT - 3'd1) begin
                        w_next    = IDLE;
                        w_timeout = 1'b1;
                    end
                end
                // entry index only reads 0 here once entry 7 has been accepted
                ACTIVE: if (!bus.isAlive_in) w_next = (r_entry == 3'd0) ? DONE : IDLE;
                DONE:   w_next = DONE;
                HALT:   w_next = HALT;
                default: w_next = IDLE;
            endcase
        end
    end

    // Frame-edge detector, scroll counter and ARM wait counter.
    always_ff @(posedge Clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_frame_prev <= 1'b0;
            r_scroll     <= 6'd0;
            r_arm_cnt    <= 3'd0;
        end else begin
            r_frame_prev <= frame_clk;
            if (restart)
                r_scroll <= 6'd0;
            else if (w_frame_rise && Shift && r_state != HALT && r_scroll != 6'd63)
                r_scroll <= r_scroll + 6'd1;
            if (r_state == ISSUE)    r_arm_cnt <= 3'd0;
            else if (r_state == ARM) r_arm_cnt <= r_arm_cnt + 3'd1;
        end
    end

    // Registered outputs, loaded from the next-state decision.
    always_ff @(posedge Clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_start   <= 1'b0;
            r_kill    <= 1'b0;
            r_spawn_x <= 10'd0;
            r_spawn_y <= 10'd0;
            r_entry   <= 3'd0;
            r_done    <= 1'b0;
            r_hit     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_start <= (w_next == ISSUE);
            r_kill  <= w_kill_req;
            if (w_next == ISSUE) begin
                r_spawn_x <= SPAWN_X;
                r_spawn_y <= y_of(r_entry);
            end
            if (restart) begin
                r_entry <= 3'd0;
                r_done  <= 1'b0;
                r_hit   <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                if (w_accept)                             r_entry <= r_entry + 3'd1;
                if (w_next == DONE)                       r_done  <= 1'b1;
                if (bus.kill_Mario && r_state != HALT)    r_hit   <= 1'b1;
                if (w_timeout)                            r_err   <= 1'b1;
            end
        end
    end

    assign bus.start    = r_start;
    assign bus.kill     = r_kill;
    assign bus.spawnX   = r_spawn_x;
    assign bus.spawnY   = r_spawn_y;
    assign scroll_count = r_scroll;
    assign entry_idx    = r_entry;
    assign spawns_done  = r_done;
    assign mario_hit    = r_hit;
    assign spawn_err    = r_err;

endmodule

// File: tb/tb_goomba_spawner.sv
// Directed testbench for goomba_spawner.
module tb_goomba_spawner;

    logic       Clk;
    logic       Reset_n;
    logic       frame_clk;
    logic       Shift;
    logic       restart;
    logic [5:0] scroll_count;
    logic [2:0] entry_idx;
    logic       spawns_done;
    logic       mario_hit;
    logic       spawn_err;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;

    goomba_spawner_if u_if ();

    goomba_spawner dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .Shift        (Shift),
        .restart      (restart),
        .bus          (u_if),
        .scroll_count (scroll_count),
        .entry_idx    (entry_idx),
        .spawns_done  (spawns_done),
        .mario_hit    (mario_hit),
        .spawn_err    (spawn_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) if (u_if.start === 1'b1) start_cnt++;

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic frame_edge(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            @(negedge Clk);
            frame_clk = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (u_if.start === 1'b1) ok = 1'b1;
            else @(negedge Clk);
        end
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; frame_clk = 1'b0; Shift = 1'b0; restart = 1'b0;
        u_if.isAlive_in = 1'b0; u_if.kill_Mario = 1'b0;
        tick(3);
        n_checks++; if ({u_if.start, u_if.kill} !== 2'b00) begin n_fail++; $display("FAIL reset_start_kill: got %b want 00", {u_if.start, u_if.kill}); end
        n_checks++; if ({u_if.spawnX, u_if.spawnY} !== 20'd0) begin n_fail++; $display("FAIL reset_spawnxy: got %0d/%0d want 0/0", u_if.spawnX, u_if.spawnY); end
        n_checks++; if (scroll_count !== 6'd0 || entry_idx !== 3'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", scroll_count, entry_idx); end
        n_checks++; if ({spawns_done, mario_hit, spawn_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {spawns_done, mario_hit, spawn_err}); end
        Reset_n = 1'b1; Shift = 1'b1;
        tick(3);
        n_checks++; if (u_if.start !== 1'b0) begin n_fail++; $display("FAIL post_reset_start: got %b want 0", u_if.start); end
    endtask

    task automatic test_arm_timeout;
        bit ok;
        u_if.isAlive_in = 1'b0;
        frame_edge(2);
        wait_start(10, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL first_start: got no start want start"); end
        n_checks++; if (u_if.spawnX !== 10'd480 || u_if.spawnY !== 10'd400) begin n_fail++; $display("FAIL first_xy: got %0d/%0d want 480/400", u_if.spawnX, u_if.spawnY); end
        tick(4);
        n_checks++; if (spawn_err !== 1'b0) begin n_fail++; $display("FAIL err_early: got %b want 0", spawn_err); end
        tick(1);
        n_checks++; if (spawn_err !== 1'b1) begin n_fail++; $display("FAIL err_timeout: got %b want 1", spawn_err); end
        n_checks++; if (entry_idx !== 3'd0) begin n_fail++; $display("FAIL err_entry: got %0d want 0", entry_idx); end
        n_checks++; if (u_if.spawnX !== 10'd480 || u_if.spawnY !== 10'd400) begin n_fail++; $display("FAIL xy_hold: got %0d/%0d want 480/400", u_if.spawnX, u_if.spawnY); end
        wait_start(5, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL retry_start: got no start want start"); end
    endtask

    task automatic test_arm_accept;
        tick(2);
        u_if.isAlive_in = 1'b1;
        tick(1);
        n_checks++; if (entry_idx !== 3'd1) begin n_fail++; $display("FAIL accept_entry: got %0d want 1", entry_idx); end
        n_checks++; if (spawn_err !== 1'b1 || u_if.start !== 1'b0) begin n_fail++; $display("FAIL accept_flags: got err=%b start=%b want 1/0", spawn_err, u_if.start); end
    endtask

    task automatic test_late_spawn;
        bit ok;
        int snap;
        u_if.isAlive_in = 1'b0;
        frame_edge(3);
        wait_start(10, ok);
        n_checks++; if (ok !== 1'b1 || u_if.spawnY !== 10'd400) begin n_fail++; $display("FAIL entry1_start: got ok=%b y=%0d want 1/400", ok, u_if.spawnY); end
        u_if.isAlive_in = 1'b1;
        tick(2);
        n_checks++; if (entry_idx !== 3'd2) begin n_fail++; $display("FAIL entry1_accept: got %0d want 2", entry_idx); end
        snap = start_cnt;
        frame_edge(5);
        n_checks++; if (scroll_count !== 6'd10) begin n_fail++; $display("FAIL scroll10: got %0d want 10", scroll_count); end
        n_checks++; if (start_cnt !== snap) begin n_fail++; $display("FAIL alive_blocks: got %0d starts want 0", start_cnt - snap); end
        u_if.isAlive_in = 1'b0;
        wait_start(10, ok);
        n_checks++; if (ok !== 1'b1 || u_if.spawnY !== 10'd320) begin n_fail++; $display("FAIL late_spawn: got ok=%b y=%0d want 1/320", ok, u_if.spawnY); end
        u_if.isAlive_in = 1'b1;
        tick(2);
        n_checks++; if (entry_idx !== 3'd3) begin n_fail++; $display("FAIL late_accept: got %0d want 3", entry_idx); end
    endtask

    task automatic test_kill_mario;
        int snap;
        u_if.kill_Mario = 1'b1;
        tick(1);
        u_if.kill_Mario = 1'b0;
        n_checks++; if (u_if.kill !== 1'b1 || mario_hit !== 1'b1) begin n_fail++; $display("FAIL hit_kill: got kill=%b hit=%b want 1/1", u_if.kill, mario_hit); end
        tick(1);
        n_checks++; if (u_if.kill !== 1'b0) begin n_fail++; $display("FAIL hit_kill_pulse: got %b want 0", u_if.kill); end
        snap = start_cnt;
        u_if.isAlive_in = 1'b0;
        frame_edge(3);
        n_checks++; if (start_cnt !== snap || scroll_count !== 6'd10) begin n_fail++; $display("FAIL halt_ignores: got starts=%0d scroll=%0d want 0/10", start_cnt - snap, scroll_count); end
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        n_checks++; if (u_if.kill !== 1'b1) begin n_fail++; $display("FAIL restart_kill: got %b want 1", u_if.kill); end
        n_checks++; if (scroll_count !== 6'd0 || entry_idx !== 3'd0) begin n_fail++; $display("FAIL restart_counts: got %0d/%0d want 0/0", scroll_count, entry_idx); end
        n_checks++; if ({mario_hit, spawn_err, spawns_done} !== 3'b000) begin n_fail++; $display("FAIL restart_flags: got %b want 000", {mario_hit, spawn_err, spawns_done}); end
        tick(1);
        n_checks++; if (u_if.kill !== 1'b0) begin n_fail++; $display("FAIL restart_kill_pulse: got %b want 0", u_if.kill); end
    endtask

    task automatic test_saturate_done;
        bit ok;
        int snap;
        int ys[8] = '{400, 400, 320, 400, 400, 320, 400, 400};
        u_if.isAlive_in = 1'b1;
        frame_edge(70);
        n_checks++; if (scroll_count !== 6'd63) begin n_fail++; $display("FAIL saturate: got %0d want 63", scroll_count); end
        for (int i = 0; i < 8; i++) begin
            u_if.isAlive_in = 1'b0;
            wait_start(10, ok);
            n_checks++; if (ok !== 1'b1 || u_if.spawnY !== 10'(ys[i])) begin n_fail++; $display("FAIL table_spawn%0d: got ok=%b y=%0d want 1/%0d", i, ok, u_if.spawnY, ys[i]); end
            u_if.isAlive_in = 1'b1;
            tick(2);
            n_checks++; if (entry_idx !== 3'((i + 1) % 8)) begin n_fail++; $display("FAIL table_entry%0d: got %0d want %0d", i, entry_idx, (i + 1) % 8); end
        end
        u_if.isAlive_in = 1'b0;
        tick(2);
        n_checks++; if (spawns_done !== 1'b1) begin n_fail++; $display("FAIL done_flag: got %b want 1", spawns_done); end
        snap = start_cnt;
        tick(20);
        n_checks++; if (start_cnt !== snap) begin n_fail++; $display("FAIL done_no_start: got %0d starts want 0", start_cnt - snap); end
    endtask

    task automatic test_reset_mid_arm;
        bit ok;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        u_if.isAlive_in = 1'b0;
        frame_edge(2);
        wait_start(10, ok);
        tick(1);
        n_checks++; if (ok !== 1'b1 || u_if.spawnX !== 10'd480) begin n_fail++; $display("FAIL pre_reset_arm: got ok=%b x=%0d want 1/480", ok, u_if.spawnX); end
        #2 Reset_n = 1'b0;
        #1;
        n_checks++; if ({u_if.start, u_if.kill, u_if.spawnX, u_if.spawnY} !== 22'd0) begin n_fail++; $display("FAIL async_reset_bus: got x=%0d y=%0d want 0/0", u_if.spawnX, u_if.spawnY); end
        n_checks++; if ({scroll_count, entry_idx, spawns_done, mario_hit, spawn_err} !== 12'd0) begin n_fail++; $display("FAIL async_reset_status: got scroll=%0d want 0", scroll_count); end
        @(negedge Clk);
        Reset_n = 1'b1;
        tick(3);
        frame_edge(1);
        restart = 1'b1; u_if.kill_Mario = 1'b1;
        tick(1);
        restart = 1'b0; u_if.kill_Mario = 1'b0;
        n_checks++; if (u_if.kill !== 1'b1 || mario_hit !== 1'b0 || scroll_count !== 6'd0) begin n_fail++; $display("FAIL restart_vs_hit: got kill=%b hit=%b scroll=%0d want 1/0/0", u_if.kill, mario_hit, scroll_count); end
        frame_edge(2);
        wait_start(10, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL restart_to_idle: got no start want start"); end
    endtask

    initial begin
        test_reset();
        test_arm_timeout();
        test_arm_accept();
        test_late_spawn();
        test_kill_mario();
        test_saturate_done();
        test_reset_mid_arm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
